// File: rtl/debounce_pkg.sv
// debounce_pkg -- shared definitions for the debounce_edge block.
//   state_e               : debouncer FSM states (2 bits)
//   DEFAULT_STABLE_CYCLES : default qualification length in clock cycles
//   DEFAULT_LONG_CYCLES   : default long-press hold length in clock cycles
//   cnt_width()           : width needed to hold the values 0..limit
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_e;

  localparam int DEFAULT_STABLE_CYCLES = 16;
  localparam int DEFAULT_LONG_CYCLES   = 1024;

  // Bits needed to represent every value from 0 up to and including limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_sat_counter.sv
// sat_counter -- up-counter with synchronous clear, count enable and
// saturation at LIMIT.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset, count returns to 0
//   clr   : clear to 0 on the next edge (has priority over en)
//   en    : count up by one on the next edge unless already at LIMIT
//   count : current count
//   term  : count is at LIMIT
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT_V)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == LIMIT_V);

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge -- debouncer and edge detector for an already-synchronised
// level. A new level is accepted only after STABLE_CYCLES consecutive
// samples; the accepted change is reported with a one-cycle pulse.
// Optional long-press detection is built when DEBOUNCE_LONG_PRESS_EN is
// defined.
//   clk        : clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset
//   sync_in    : synchroniser output, synchronous to clk
//   db_out     : debounced level (registered)
//   rise_pulse : one cycle with the debounced 0->1 change (registered)
//   fall_pulse : one cycle with the debounced 1->0 change (registered)
//   long_press : one cycle after db_out has been high for LONG_CYCLES
//                cycles (only with DEBOUNCE_LONG_PRESS_EN)
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam int CW     = cnt_width(STABLE_CYCLES);
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  // Elaboration-time parameter range checks.
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
    $error("debounce_edge: STABLE_CYCLES out of range 1..65535");
  end
  if (LONG_CYCLES < 1 || LONG_CYCLES > 1048575) begin : g_bad_long
    $error("debounce_edge: LONG_CYCLES out of range 1..2^20-1");
  end

  state_e state_q, state_d;
  logic   db_q, db_d;
  logic   rise_q, rise_d;
  logic   fall_q, fall_d;

  logic          stab_clr;
  logic          stab_en;
  logic          stab_term;
  logic [CW-1:0] stab_cnt;

  // Next-state logic. The stability count equals the number of consecutive
  // samples of the new level seen so far, so reaching STABLE_CYCLES-1 while
  // sampling the new level once more completes qualification.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync_in) begin
          if (SINGLE) begin
            state_d = S_HIGH;
            db_d    = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = S_RISE;
          end
        end
      end
      S_RISE: begin
        if (!sync_in) begin
          state_d = S_LOW;
        end else if (stab_term) begin
          state_d = S_HIGH;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          if (SINGLE) begin
            state_d = S_LOW;
            db_d    = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = S_FALL;
          end
        end
      end
      S_FALL: begin
        if (sync_in) begin
          state_d = S_HIGH;
        end else if (stab_term) begin
          state_d = S_LOW;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        db_d    = 1'b0;
      end
    endcase
  end

  // Landing in a stable state (accepted change or bounce) discards any
  // partial count; every other edge is one more qualifying sample.
  assign stab_clr = (state_d == S_LOW) || (state_d == S_HIGH);
  assign stab_en  = !stab_clr;

  sat_counter #(
    .WIDTH (CW),
    .LIMIT (STABLE_CYCLES - 1)
  ) u_stab_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stab_clr),
    .en    (stab_en),
    .count (stab_cnt),
    .term  (stab_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int             LW       = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0]  LONG_PRE = LW'(LONG_CYCLES - 1);

  logic          long_clr;
  logic          long_en;
  logic          long_term;
  logic [LW-1:0] long_cnt;
  logic          long_q, long_d;

  // S_FALL keeps counting so a short low glitch does not restart the hold.
  assign long_en  = (state_q == S_HIGH) || (state_q == S_FALL);
  assign long_clr = rise_d || (state_d == S_LOW);

  sat_counter #(
    .WIDTH (LW),
    .LIMIT (LONG_CYCLES)
  ) u_long_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (long_clr),
    .en    (long_en),
    .count (long_cnt),
    .term  (long_term)
  );

  // Fire on the edge where the count steps onto LONG_CYCLES; saturation
  // then holds it there so the pulse cannot repeat in the same high period.
  always_comb begin
    long_d = 1'b0;
    if (long_en && !long_clr && !long_term && (long_cnt == LONG_PRE)) begin
      long_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= 1'b0;
    end else begin
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge -- directed bench for debounce_edge.
// Instance A: STABLE_CYCLES=4, LONG_CYCLES=10. Instance B: STABLE_CYCLES=1.
// Observed vector per instance is {db_out, rise_pulse, fall_pulse, long_press}.
module tb_debounce_edge;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sync_a = 1'b0;
  logic sync_b = 1'b0;
  logic db_a, rise_a, fall_a, long_a;
  logic db_b, rise_b, fall_b, long_b;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  localparam logic [3:0] V_IDLE = 4'b0000;
  localparam logic [3:0] V_RISE = 4'b1100;
  localparam logic [3:0] V_HIGH = 4'b1000;
  localparam logic [3:0] V_FALL = 4'b0010;
  localparam logic [3:0] V_LONG = 4'b1001;

  always #5 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(4), .LONG_CYCLES(10)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_in    (sync_a),
    .db_out     (db_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a)
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    .long_press (long_a)
`endif
  );

  debounce_edge #(.STABLE_CYCLES(1), .LONG_CYCLES(10)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_in    (sync_b),
    .db_out     (db_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b)
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    .long_press (long_b)
`endif
  );

`ifndef DEBOUNCE_LONG_PRESS_EN
  assign long_a = 1'b0;
  assign long_b = 1'b0;
`endif

  function automatic logic [3:0] obs(input bit sel);
    return sel ? {db_b, rise_b, fall_b, long_b} : {db_a, rise_a, fall_a, long_a};
  endfunction

  task automatic check_now(input bit sel, input logic [3:0] exp, input string tag);
    logic [3:0] o;
    o = obs(sel);
    checks++;
    $display("t=%0t %s dut=%s observed=%b expected=%b", $time, tag, sel ? "B" : "A", o, exp);
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // Drive one sample, queue its expected result, then check after the edge.
  task automatic step(input bit sel, input logic in, input logic [3:0] exp, input string tag);
    logic [3:0] e;
    string      t;
    if (sel) sync_b = in;
    else     sync_a = in;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_now(sel, e, t);
  endtask

  initial begin
    logic [6:0] bounce_pat;
    logic       in;

    // Reset held while inputs toggle: everything stays 0.
    for (int i = 0; i < 4; i++) begin
      sync_a = ~sync_a;
      sync_b = ~sync_b;
      @(posedge clk);
      #1;
      check_now(1'b0, V_IDLE, $sformatf("reset_hold_a%0d", i));
      check_now(1'b1, V_IDLE, $sformatf("reset_hold_b%0d", i));
    end
    sync_a = 1'b0;
    sync_b = 1'b0;
    rst_n  = 1'b1;

    // Clean rise: accepted on the 4th sampling edge, pulse lasts one cycle.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, V_IDLE, $sformatf("rise_wait%0d", i));
    step(1'b0, 1'b1, V_RISE, "rise_edge");
    step(1'b0, 1'b1, V_HIGH, "rise_after");

    // Clean fall.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, V_HIGH, $sformatf("fall_wait%0d", i));
    step(1'b0, 1'b0, V_FALL, "fall_edge");
    step(1'b0, 1'b0, V_IDLE, "fall_after");

    // Bounce 1,1,1,0,1,1,1,1: rise only on the 8th edge.
    bounce_pat = 7'b1110111;
    for (int i = 0; i < 7; i++) step(1'b0, bounce_pat[6-i], V_IDLE, $sformatf("bounce%0d", i + 1));
    step(1'b0, 1'b1, V_RISE, "bounce_rise");
    step(1'b0, 1'b1, V_HIGH, "bounce_hold");

    // Three-cycle low glitch is rejected.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, V_HIGH, $sformatf("glitch%0d", i));
    step(1'b0, 1'b1, V_HIGH, "glitch_back");

    // Fall back to low.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, V_HIGH, $sformatf("fall2_wait%0d", i));
    step(1'b0, 1'b0, V_FALL, "fall2_edge");

    // STABLE_CYCLES=1: every change is followed on the next edge.
    step(1'b1, 1'b1, V_RISE, "s1_rise1");
    step(1'b1, 1'b0, V_FALL, "s1_fall1");
    step(1'b1, 1'b1, V_RISE, "s1_rise2");
    step(1'b1, 1'b0, V_FALL, "s1_fall2");
    step(1'b1, 1'b0, V_IDLE, "s1_low");
    step(1'b1, 1'b1, V_RISE, "s1_rise3");
    step(1'b1, 1'b1, V_HIGH, "s1_high");
    step(1'b1, 1'b0, V_FALL, "s1_fall3");

`ifdef DEBOUNCE_LONG_PRESS_EN
    // Long press: one pulse 10 cycles after rise_pulse, unaffected by
    // 2-cycle low glitches before and after it fires.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, V_IDLE, $sformatf("lp_wait%0d", i));
    step(1'b0, 1'b1, V_RISE, "lp_rise");
    for (int k = 1; k <= 20; k++) begin
      in = !(k == 3 || k == 4 || k == 13 || k == 14);
      step(1'b0, in, (k == 10) ? V_LONG : V_HIGH, $sformatf("lp_hold%0d", k));
    end
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, V_HIGH, $sformatf("lp_fall_wait%0d", i));
    step(1'b0, 1'b0, V_FALL, "lp_fall_edge");
`endif

    // Asynchronous reset mid-cycle clears a live rise_pulse immediately.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, V_IDLE, $sformatf("ar_wait%0d", i));
    step(1'b0, 1'b1, V_RISE, "ar_rise");
    #2;
    rst_n = 1'b0;
    #1;
    check_now(1'b0, V_IDLE, "async_reset_a");
    check_now(1'b1, V_IDLE, "async_reset_b");
    @(posedge clk);
    #1;
    check_now(1'b0, V_IDLE, "reset_held_edge");

    // Release with sync_in=1: rise after STABLE_CYCLES edges.
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, V_IDLE, $sformatf("rel_wait%0d", i));
    step(1'b0, 1'b1, V_RISE, "rel_rise");
    step(1'b0, 1'b1, V_HIGH, "rel_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Debouncer and edge detector that sits directly downstream of the two-flop synchronizer.
- Consumes the synchronizer's already-synchronous output and produces a filtered level plus single-cycle rise and fall pulses for control logic (buttons, strap pins, slow status lines).
- A level change is accepted only after it has held for a programmable number of consecutive clock cycles.

Parameters:
- STABLE_CYCLES, 16, consecutive sampled cycles the new level must hold before db_out changes; legal range 1..65535.
- LONG_CYCLES, 1024, cycles db_out must stay high before long_press fires; used only when the optional feature is enabled; legal range 1..2^20-1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sync_in  input  1  level from the synchronizer; treated as synchronous to clk.
- db_out  output  1  debounced level, registered.
- rise_pulse  output  1  one-cycle pulse on a debounced 0->1 transition, registered.
- fall_pulse  output  1  one-cycle pulse on a debounced 1->0 transition, registered.
- long_press  output  1  one-cycle pulse on long hold (present only with DEBOUNCE_LONG_PRESS_EN).

Behaviour:
- Reset values (asynchronous, immediate):
  - db_out=0, rise_pulse=0, fall_pulse=0, long_press=0.
  - State=S_LOW, stability counter=0, long counter=0.
- Counter width is CW=$clog2(STABLE_CYCLES+1). No truncation is allowed.
- States:
  - S_LOW: db_out=0.
    - sync_in=1 -> S_RISE, cnt=1.
    - If STABLE_CYCLES=1, instead go straight to S_HIGH and fire rise_pulse on this edge.
  - S_RISE:
    - sync_in=0 -> S_LOW, cnt=0 (bounce rejected, no pulse).
    - sync_in=1 and cnt==STABLE_CYCLES-1 -> S_HIGH; db_out<=1; rise_pulse<=1.
    - Otherwise cnt++.
  - S_HIGH and S_FALL: mirror images of S_LOW and S_RISE with inverted polarity; the accepted transition drives db_out<=0 and fall_pulse<=1.
- Latency: db_out and the matching pulse update on the STABLE_CYCLES-th consecutive rising edge that samples the new level.
- rise_pulse and fall_pulse:
  - Each is exactly one cycle wide.
  - They are never asserted together.
  - Every pulse coincides with the db_out change it reports.
- Bounces: any sample equal to the current db_out during S_RISE or S_FALL fully restarts qualification. Partial counts are never retained.
- Reset mid-qualification: the count is discarded.
- Reset released with sync_in=1: db_out rises after STABLE_CYCLES edges and rise_pulse fires. This is intended; downstream logic must tolerate it.
- Counters never wrap. cnt is bounded by STABLE_CYCLES-1 by construction.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- With the macro defined:
  - A long counter clears on rise_pulse and increments each cycle while in S_HIGH or S_FALL, saturating at LONG_CYCLES.
  - long_press pulses for one cycle when the counter reaches LONG_CYCLES. This happens at most once per debounced high period.
  - Entering S_LOW clears the counter.
  - A bounce that returns from S_FALL to S_HIGH does not clear it.
- Without the macro: the long_press port, the long counter and LONG_CYCLES logic are absent from the module.

Decomposition:
- Shared package debounce_pkg contains:
  - The state enum (S_LOW, S_RISE, S_HIGH, S_FALL), 2 bits.
  - Width helper constant functions.
  - Default STABLE_CYCLES and LONG_CYCLES constants.
- One sub-module is natural: sat_counter (parameterised width, clear, enable, saturate-at-limit, terminal flag).
  - Instantiated once for stability.
  - Instantiated a second time for long-press when the feature is enabled.

Test Plan:
1. Reset: hold rst_n=0 with sync_in toggling -> db_out, rise_pulse, fall_pulse and long_press stay 0. Assert rst_n mid-cycle -> outputs clear without waiting for a clock edge.
2. Clean rise (STABLE_CYCLES=4): sync_in 0->1 held -> db_out=1 and rise_pulse=1 on the 4th sampling edge. rise_pulse=0 on the 5th edge. No fall_pulse.
3. Bounce rejection (STABLE_CYCLES=4): sync_in pattern 1,1,1,0,1,1,1,1 -> db_out rises only at the 8th edge. Exactly one rise_pulse.
4. Clean fall and symmetry: from db_out=1, sync_in=0 held 4 cycles -> fall_pulse for one cycle with db_out=0 on the same edge. A 3-cycle low glitch -> no change.
5. Boundary STABLE_CYCLES=1: each sync_in change -> db_out follows after 1 edge, with a pulse each time. Alternating sync_in -> pulses alternate rise and fall with none missing.
6. With DEBOUNCE_LONG_PRESS_EN, LONG_CYCLES=10, STABLE_CYCLES=4:
   - Hold high 20 cycles after rise -> exactly one long_press, 10 cycles after rise_pulse.
   - A 2-cycle low glitch during the hold -> no re-fire and no reset of the long count.
